// File: rtl/dmem_stream_port_if.sv
// Stream and memory-port bundle of the data-memory fill/drain engine.
// The slave modport is the engine side; the master modport is the element/memory environment.
interface dmem_stream_port_if #(
    parameter int unsigned ELEM_SIZE = 8,
    parameter int unsigned VECT_SIZE = 8
);
    localparam int unsigned DATA_W = ELEM_SIZE * VECT_SIZE;

    logic                 in_valid;
    logic [ELEM_SIZE-1:0] in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic [ELEM_SIZE-1:0] out_data;
    logic                 out_ready;
    logic                 mem_we;
    logic [DATA_W-1:0]    mem_a;
    logic [DATA_W-1:0]    mem_wd;
    logic [DATA_W-1:0]    mem_rd;

    modport master (
        output in_valid, in_data, out_ready, mem_rd,
        input  in_ready, out_valid, out_data, mem_we, mem_a, mem_wd
    );

    modport slave (
        input  in_valid, in_data, out_ready, mem_rd,
        output in_ready, out_valid, out_data, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/dmem_stream_port.sv
// Packs a byte-element stream into vector lines written to data memory (LOAD),
// and reads every line back out as an element stream (DUMP).
module dmem_stream_port #(
    parameter int unsigned MEMO_LINES = 64,
    parameter int unsigned VECT_SIZE  = 8,
    parameter int unsigned ELEM_SIZE  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_load,
    input  logic              start_dump,
    output logic              busy,
    output logic              done,
    dmem_stream_port_if.slave bus
);
    localparam int unsigned LINE_W = $clog2(MEMO_LINES);
    localparam int unsigned ELEM_W = $clog2(VECT_SIZE);
    localparam int unsigned DATA_W = ELEM_SIZE * VECT_SIZE;
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(MEMO_LINES - 1);
    localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(VECT_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DUMP,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [LINE_W-1:0] line, line_nxt;
    logic [ELEM_W-1:0] elem, elem_nxt;
    logic [DATA_W-1:0] pack, pack_nxt;

    logic              in_ready_q;
    logic              out_valid_q;
    logic              mem_we_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] mem_a_q;
    logic [DATA_W-1:0] mem_wd_q;

    // State, counters and pack register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            line  <= '0;
            elem  <= '0;
            pack  <= '0;
        end else begin
            state <= state_nxt;
            line  <= line_nxt;
            elem  <= elem_nxt;
            pack  <= pack_nxt;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_nxt = state;
        line_nxt  = line;
        elem_nxt  = elem;
        pack_nxt  = pack;
        unique case (state)
            S_IDLE: begin
                if (start_load) begin
                    state_nxt = S_LOAD;
                    line_nxt  = '0;
                    elem_nxt  = '0;
                end else if (start_dump) begin
                    state_nxt = S_DUMP;
                    line_nxt  = '0;
                    elem_nxt  = '0;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    pack_nxt[32'(elem) * ELEM_SIZE +: ELEM_SIZE] = bus.in_data;
                    if (elem == LAST_ELEM) begin
                        elem_nxt  = '0;
                        state_nxt = S_WRITE;
                    end else begin
                        elem_nxt = elem + ELEM_W'(1);
                    end
                end
            end
            S_WRITE: begin
                if (line == LAST_LINE) begin
                    line_nxt  = '0;
                    state_nxt = S_DONE;
                end else begin
                    line_nxt  = line + LINE_W'(1);
                    state_nxt = S_LOAD;
                end
            end
            S_DUMP: begin
                if (bus.out_ready) begin
                    if (elem == LAST_ELEM) begin
                        elem_nxt = '0;
                        if (line == LAST_LINE) begin
                            line_nxt  = '0;
                            state_nxt = S_DONE;
                        end else begin
                            line_nxt = line + LINE_W'(1);
                        end
                    end else begin
                        elem_nxt = elem + ELEM_W'(1);
                    end
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output flags and memory port decoded one cycle early so they register with the state
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_a_q     <= '0;
            mem_wd_q    <= '0;
        end else begin
            in_ready_q  <= (state_nxt == S_LOAD);
            out_valid_q <= (state_nxt == S_DUMP);
            mem_we_q    <= (state_nxt == S_WRITE);
            busy_q      <= (state_nxt == S_LOAD) || (state_nxt == S_WRITE) || (state_nxt == S_DUMP);
            done_q      <= (state_nxt == S_DONE);
            mem_a_q     <= ((state_nxt == S_WRITE) || (state_nxt == S_DUMP))
                           ? DATA_W'({line_nxt, 2'b00}) : '0;
            mem_wd_q    <= (state_nxt == S_WRITE) ? pack_nxt : '0;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_a     = mem_a_q;
    assign bus.mem_wd    = mem_wd_q;
    assign busy          = busy_q;
    assign done          = done_q;

    // Read data is combinational from memory, so the lane select cannot be registered
    assign bus.out_data = out_valid_q ? bus.mem_rd[32'(elem) * ELEM_SIZE +: ELEM_SIZE] : '0;
endmodule

// File: tb/tb_dmem_stream_port.sv
// Scoreboard bench for dmem_stream_port: random loads/dumps against a line-level memory model.
module tb_dmem_stream_port;
    localparam int unsigned ML = 64;
    localparam int unsigned VS = 8;
    localparam int unsigned ES = 8;
    localparam int unsigned DW = ES * VS;

    logic clk = 1'b0;
    logic reset;
    logic start_load;
    logic start_dump;
    logic busy;
    logic done;

    dmem_stream_port_if #(.ELEM_SIZE(ES), .VECT_SIZE(VS)) bus ();

    dmem_stream_port #(.MEMO_LINES(ML), .VECT_SIZE(VS), .ELEM_SIZE(ES)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_load (start_load),
        .start_dump (start_dump),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Environment memory with combinational read
    logic [DW-1:0] tb_mem [ML];
    always @(posedge clk) if (bus.mem_we) tb_mem[bus.mem_a[7:2]] <= bus.mem_wd;
    assign bus.mem_rd = tb_mem[bus.mem_a[7:2]];

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           exp_wr_q[$];
    logic [7:0]    exp_out_q[$];
    int            wr_cyc_q[$];
    logic [DW-1:0] ref_mem [ML];
    logic [DW-1:0] cap_a   [ML];
    logic [DW-1:0] cap_wd  [ML];
    int            n_chk   = 0;
    int            n_pass  = 0;
    int            cyc     = 0;
    int            acc_cnt = 0;
    int            wr_cnt  = 0;
    bit            stall_prev = 1'b0;
    logic [7:0]    held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops expectations whenever the DUT writes memory or completes an output beat
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.in_valid && bus.in_ready) acc_cnt++;
            if (bus.mem_we) begin
                wr_t e;
                if (wr_cnt < int'(ML)) begin
                    cap_a[wr_cnt]  = bus.mem_a;
                    cap_wd[wr_cnt] = bus.mem_wd;
                end
                wr_cyc_q.push_back(cyc);
                check("write_after_fill", 64'(acc_cnt >= 8 * (wr_cnt + 1)), 64'd1);
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_write", 64'd1, 64'd0);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr", bus.mem_a, e.a);
                    check("wr_data", bus.mem_wd, e.d);
                end
                wr_cnt++;
            end
            if (stall_prev && bus.out_valid) check("stall_hold", 64'(bus.out_data), 64'(held));
            stall_prev = bus.out_valid && !bus.out_ready;
            held       = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_out_q.size() == 0) check("unexpected_output", 64'd1, 64'd0);
                else check("out_data", 64'(bus.out_data), 64'(exp_out_q.pop_front()));
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic do_reset(input int n);
        for (int i = 0; i <= n; i++) begin
            @(posedge clk); #1;
            reset         = 1'b1;
            start_load    = 1'($urandom);
            start_dump    = 1'($urandom);
            bus.in_valid  = 1'($urandom);
            bus.in_data   = 8'($urandom);
            bus.out_ready = 1'($urandom);
            @(negedge clk);
            if (i > 0)
                check("reset_outputs",
                      64'({bus.in_ready, bus.out_valid, bus.mem_we, busy, done,
                           |bus.mem_a, |bus.mem_wd, |bus.out_data}), 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0; start_load = 1'b0; start_dump = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 64'({busy, bus.in_ready, bus.out_valid, bus.mem_we}), 64'd0);
    endtask

    // mode: 0 in_valid held high, 1 every other cycle, 2 random gaps
    task automatic run_load(input bit seq, input int mode, input bit both_start,
                            input int poke_at, input int stop_after, input bit chk_timing);
        logic [7:0]    b [512];
        logic [DW-1:0] line_d;
        int            idx, guard, c0, bad;
        bit            v, got_done;
        for (int n = 0; n < 512; n++) b[n] = seq ? 8'(n) : 8'($urandom);
        for (int l = 0; l < stop_after / 8; l++) begin
            line_d = '0;
            for (int e = 0; e < 8; e++) line_d[8*e +: 8] = b[8*l + e];
            exp_wr_q.push_back('{a: DW'(4 * l), d: line_d});
            ref_mem[l] = line_d;
        end
        acc_cnt = 0; wr_cnt = 0; wr_cyc_q.delete();
        @(posedge clk); #1;
        start_load = 1'b1; start_dump = both_start; c0 = cyc;
        @(posedge clk); #1;
        start_load = 1'b0; start_dump = 1'b0;
        if (both_start) begin
            check("conflict_in_ready", 64'(bus.in_ready), 64'd1);
            check("conflict_out_valid", 64'(bus.out_valid), 64'd0);
        end
        idx = 0; guard = 0;
        while (idx < stop_after && guard < 4000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bus.in_valid = v;
            bus.in_data  = b[idx];
            start_dump   = (idx == poke_at);
            if (v && bus.in_ready) idx++;
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid = 1'b0; start_dump = 1'b0;
        check("load_accepts", 64'(idx), 64'(stop_after));
        if (stop_after < 512) return;
        got_done = 1'b0;
        for (int i = 0; i < 50 && !got_done; i++) begin
            @(negedge clk);
            if (done) got_done = 1'b1;
        end
        check("load_done_seen", 64'(got_done), 64'd1);
        if (chk_timing) check("load_done_cycle", 64'(cyc - c0), 64'd577);
        @(negedge clk);
        check("done_one_cycle", 64'({done, busy}), 64'd0);
        check("load_write_count", 64'(wr_cnt), 64'd64);
        check("load_wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
        if (chk_timing) begin
            bad = 0;
            for (int i = 0; i < wr_cyc_q.size(); i++) if (wr_cyc_q[i] != c0 + 9 + 9 * i) bad++;
            check("write_spacing_errors", 64'(bad), 64'd0);
        end
        if (seq) begin
            check("line0_addr", cap_a[0], 64'd0);
            check("line0_data", cap_wd[0], 64'h0706050403020100);
            check("line63_addr", cap_a[63], 64'd252);
            check("line63_data", cap_wd[63], 64'hFFFEFDFCFBFAF9F8);
        end
    endtask

    // mode: 0 out_ready toggles 1,0,1,0, 1 random, 2 held high
    task automatic run_dump(input int mode, input bit chk_timing);
        int c0, done_cyc;
        bit got_done;
        for (int l = 0; l < int'(ML); l++)
            for (int e = 0; e < int'(VS); e++) exp_out_q.push_back(ref_mem[l][8*e +: 8]);
        wr_cnt = 0; done_cyc = 0;
        @(posedge clk); #1;
        start_dump = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        start_dump = 1'b0;
        got_done = 1'b0;
        for (int k = 0; k < 3000 && !got_done; k++) begin
            case (mode)
                0:       bus.out_ready = (k % 2 == 0);
                1:       bus.out_ready = 1'($urandom);
                default: bus.out_ready = 1'b1;
            endcase
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        check("dump_done_seen", 64'(got_done), 64'd1);
        if (chk_timing) check("dump_done_cycle", 64'(done_cyc - c0), 64'd513);
        check("dump_beats_left", 64'(exp_out_q.size()), 64'd0);
        check("dump_no_write", 64'(wr_cnt), 64'd0);
        check("dump_idle_after", 64'({busy, bus.out_valid}), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start_load = 1'b0; start_dump = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        do_reset(3);
        run_load(1'b1, 0, 1'b0, -1, 512, 1'b1);
        run_dump(0, 1'b0);
        run_load(1'b1, 1, 1'b0, -1, 512, 1'b0);
        run_load(1'b0, 2, 1'b1, -1, 512, 1'b0);
        run_dump(2, 1'b1);
        run_load(1'b0, 2, 1'b0, 100, 512, 1'b0);
        run_load(1'b0, 2, 1'b0, -1, 19, 1'b0);
        do_reset(2);
        check("midreset_write_count", 64'(wr_cnt), 64'd2);
        check("midreset_wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
        run_load(1'b0, 2, 1'b0, -1, 512, 1'b0);
        run_dump(1, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
